tone_burst_sched: RTL and testbench
===================================

Name: tone_burst_sched

Overview:
- Schedules and shares one 555-style astable tone oscillator between two sound-effect requesters.
- Each requester has its own fixed high/low phase counts and burst length.
- Requests are latched, arbitrated by fixed priority (REQ0 > REQ1) and played as bursts, with an enforced silent gap between bursts.
- Sits between the game-logic sound triggers and the audio mixer input.

Parameters:
REQ0_HIGH, 4, OUT-high clocks per cycle for requester 0 (>=1)
REQ0_LOW, 4, OUT-low clocks per cycle for requester 0 (>=1)
REQ0_BURST, 3, oscillator cycles per burst for requester 0 (>=1)
REQ1_HIGH, 2, OUT-high clocks per cycle for requester 1 (>=1)
REQ1_LOW, 6, OUT-low clocks per cycle for requester 1 (>=1)
REQ1_BURST, 2, oscillator cycles per burst for requester 1 (>=1)
GAP_COUNTS, 5, silent clocks after each burst (0 = no gap)

Ports:
CLK  in  1  clock, all logic on posedge
RESET_N  in  1  reset, asynchronous, active-low
REQ0  in  1  trigger for requester 0, sampled each posedge
REQ1  in  1  trigger for requester 1, sampled each posedge
OUT  out  1  tone output
BUSY  out  1  high while not IDLE
ACTIVE_ID  out  1  id of the current or last granted requester
DONE  out  1  one-clock pulse when a burst completes normally

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET_N is asynchronous, active-low. While RESET_N=0: state=IDLE, all counters 0, pend0=pend1=0, OUT=0, BUSY=0, ACTIVE_ID=0, DONE=0. The first grant is possible at the first posedge after release.
- States: IDLE, HIGH, LOW, GAP. All outputs are registered or decoded from registered state only.
  - OUT = (state==HIGH).
  - BUSY = (state!=IDLE).
- Request latching:
  - pendX is set on any posedge with REQX=1.
  - pendX is cleared on the posedge that grants X; a REQX in that same cycle is absorbed, not re-queued.
  - Queue depth is one per requester: repeated pulses collapse.
- Grant rule: at a posedge where state is IDLE, or state is GAP on its last count, select X from (pendX | REQX) with priority 0 over 1. If a requester is selected:
  - ACTIVE_ID<=X.
  - Load that requester's HIGH/LOW/BURST counts.
  - state<=HIGH.
  - Otherwise: GAP end -> IDLE; IDLE stays IDLE.
  - Latency: REQ sampled at edge k in IDLE -> OUT=1 from edge k.
- HIGH: lasts exactly REQX_HIGH clocks, then LOW.
- LOW: lasts exactly REQX_LOW clocks.
  - At LOW end with burst_cnt < REQX_BURST-1: burst_cnt++, go to HIGH.
  - At LOW end of the final cycle: go to GAP (or apply the grant rule directly if GAP_COUNTS=0), and DONE=1 for the following clock only.
- GAP: OUT=0 and BUSY=1 for GAP_COUNTS clocks. Back-to-back bursts get no extra IDLE clock.
- Counter widths:
  - Phase counter: $clog2 of the max HIGH/LOW count, +1.
  - Burst counter: $clog2 of the max BURST, +1.
  - No wrap-around is possible for legal parameters.
- Burst length: REQX_BURST*(REQX_HIGH+REQX_LOW) clocks.
- Reset mid-operation:
  - OUT falls immediately (asynchronously).
  - Pending requests are lost.
  - No DONE is emitted.

Optional Feature:
Macro TONE_BURST_PREEMPT_EN.
- Defined: REQ0 (or pend0) seen while ACTIVE_ID=1 in HIGH or LOW aborts the requester-1 burst.
  - At that posedge: state<=HIGH with requester-0 counts, ACTIVE_ID<=0, pend0 cleared.
  - No GAP and no DONE for requester 1; requester 1 is not re-queued.
  - Requester 0 is never preempted.
- Undefined: no preemption; REQ0 waits in pend0 until the grant rule applies.

Test Plan:
1. REQ0 pulse at edge 0 (defaults) -> OUT high for edges 0-3, low for 4-7, pattern repeats 3x through edge 23; DONE=1 for one clock at edge 24; BUSY=1 edges 0-28; IDLE at edge 29.
2. REQ0 and REQ1 pulsed together at edge 0 -> full requester-0 burst and gap as in test 1; requester-1 HIGH starts at edge 29 with ACTIVE_ID=1; OUT 2 high / 6 low, 2 cycles; second DONE at edge 45.
3. REQ0 pulsed at edges 5, 9 and 12 during its own burst -> exactly one extra requester-0 burst, starting at edge 29.
4. RESET_N driven low at edge 10 of a burst, mid-clock -> OUT/BUSY/DONE drop to 0 immediately without a clock; after release with no REQ, stays IDLE; a REQ queued before reset is not played.
5. TONE_BURST_PREEMPT_EN defined: REQ1 at edge 0, REQ0 at edge 3 -> edge 3 enters HIGH with ACTIVE_ID=0; no DONE for requester 1; requester-0 DONE at edge 27. Undefined: requester 0 starts at edge 21 (16 clocks of burst plus 5 of gap).
6. GAP_COUNTS=0, REQ1 held high continuously -> bursts run back-to-back with no low clock beyond REQ1_LOW; DONE pulses every 16 clocks; BUSY stays 1.

Source files
------------

// File: rtl/tone_burst_sched_if.sv
// tone_burst_sched_if: trigger inputs and tone/status outputs of the tone burst scheduler.
interface tone_burst_sched_if;
  logic req0_i;
  logic req1_i;
  logic out_o;
  logic busy_o;
  logic active_id_o;
  logic done_o;
  modport master (output req0_i, req1_i, input out_o, busy_o, active_id_o, done_o);
  modport slave (input req0_i, req1_i, output out_o, busy_o, active_id_o, done_o);
endinterface

// File: rtl/tone_burst_sched.sv
// tone_burst_sched: shares one astable tone oscillator between two prioritised burst requesters.
// Define TONE_BURST_PREEMPT_EN to let requester 0 abort a running requester-1 burst.
module tone_burst_sched #(
  parameter int REQ0_HIGH  = 4,
  parameter int REQ0_LOW   = 4,
  parameter int REQ0_BURST = 3,
  parameter int REQ1_HIGH  = 2,
  parameter int REQ1_LOW   = 6,
  parameter int REQ1_BURST = 2,
  parameter int GAP_COUNTS = 5
) (
  input logic clk_i,
  input logic rst_ni,
  tone_burst_sched_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam int MAX0  = REQ0_HIGH > REQ0_LOW ? REQ0_HIGH : REQ0_LOW;
  localparam int MAX1  = REQ1_HIGH > REQ1_LOW ? REQ1_HIGH : REQ1_LOW;
  localparam int MAXPH = MAX0 > MAX1 ? MAX0 : MAX1;
  localparam int MAXB  = REQ0_BURST > REQ1_BURST ? REQ0_BURST : REQ1_BURST;
  localparam int PW = $clog2(MAXPH) + 1;
  localparam int BW = $clog2(MAXB) + 1;
  localparam int GW = $clog2(GAP_COUNTS + 1) + 1;
  localparam logic [PW-1:0] H0 = PW'(REQ0_HIGH - 1);
  localparam logic [PW-1:0] L0 = PW'(REQ0_LOW - 1);
  localparam logic [PW-1:0] H1 = PW'(REQ1_HIGH - 1);
  localparam logic [PW-1:0] L1 = PW'(REQ1_LOW - 1);
  localparam logic [BW-1:0] B0 = BW'(REQ0_BURST - 1);
  localparam logic [BW-1:0] B1 = BW'(REQ1_BURST - 1);
  localparam logic [GW-1:0] GL = GW'(GAP_COUNTS > 0 ? GAP_COUNTS - 1 : 0);
  localparam bit NOGAP = GAP_COUNTS == 0;

  logic [1:0] state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [GW-1:0] gc_q, gc_d;
  logic id_q, id_d, p0_q, p0_d, p1_q, p1_d, done_q, done_d;
  logic sel0, sel1, hi_end, lo_end, last_burst, gap_end, grant_ok, preempt, grant, gid;

  always_comb begin
    sel0 = p0_q | bus.req0_i;
    sel1 = p1_q | bus.req1_i;
    hi_end = ph_q == (id_q ? H1 : H0);
    lo_end = ph_q == (id_q ? L1 : L0);
    last_burst = bc_q == (id_q ? B1 : B0);
    gap_end = gc_q == GL;
    grant_ok = state_q == S_IDLE || (state_q == S_GAP && gap_end) ||
               (NOGAP && state_q == S_LOW && lo_end && last_burst);
`ifdef TONE_BURST_PREEMPT_EN
    preempt = id_q && (state_q == S_HIGH || state_q == S_LOW) && sel0;
`else
    preempt = 1'b0;
`endif
    grant = preempt || (grant_ok && (sel0 || sel1));
    gid = !preempt && !sel0;
    p0_d = sel0 && !(grant && !gid);
    p1_d = sel1 && !(grant && gid);
    state_d = state_q;
    ph_d = (state_q == S_HIGH || state_q == S_LOW) ? ph_q + 1'b1 : ph_q;
    bc_d = bc_q;
    gc_d = state_q == S_GAP ? gc_q + 1'b1 : gc_q;
    id_d = id_q;
    done_d = 1'b0;
    if (grant) begin
      state_d = S_HIGH;
      ph_d = '0;
      bc_d = '0;
      id_d = gid;
      done_d = !preempt && state_q == S_LOW;
    end else if (state_q == S_HIGH && hi_end) begin
      state_d = S_LOW;
      ph_d = '0;
    end else if (state_q == S_LOW && lo_end) begin
      // Mid-burst LOW end starts the next oscillator cycle; the final one retires the burst.
      state_d = last_burst ? (NOGAP ? S_IDLE : S_GAP) : S_HIGH;
      ph_d = '0;
      bc_d = last_burst ? bc_q : bc_q + 1'b1;
      gc_d = '0;
      done_d = last_burst;
    end else if (state_q == S_GAP && gap_end) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ph_q <= '0;
      bc_q <= '0;
      gc_q <= '0;
      id_q <= 1'b0;
      p0_q <= 1'b0;
      p1_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      bc_q <= bc_d;
      gc_q <= gc_d;
      id_q <= id_d;
      p0_q <= p0_d;
      p1_q <= p1_d;
      done_q <= done_d;
    end
  end

  assign bus.out_o = state_q == S_HIGH;
  assign bus.busy_o = state_q != S_IDLE;
  assign bus.active_id_o = id_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_tone_burst_sched.sv
// tb_tone_burst_sched: checks a gapped and a gapless scheduler against a timeline model.
module tb_tone_burst_sched;
  localparam int H0 = 4, LO0 = 4, B0 = 3, H1 = 2, LO1 = 6, B1 = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0, bad = 0;
  int gap[2] = '{5, 0};
  int el[2];
  bit mb[2], mo[2], p0[2], p1[2], md[2];

  always #5 clk = ~clk;

  tone_burst_sched_if a();
  tone_burst_sched_if b();
  tone_burst_sched u_a (.clk_i(clk), .rst_ni(rst_n), .bus(a));
  tone_burst_sched #(.GAP_COUNTS(0)) u_b (.clk_i(clk), .rst_ni(rst_n), .bus(b));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per(bit o);
    return o ? H1 + LO1 : H0 + LO0;
  endfunction

  function automatic int blen(bit o);
    return o ? B1 * (H1 + LO1) : B0 * (H0 + LO0);
  endfunction

  function automatic bit exp_out(int i);
    return mb[i] && el[i] < blen(mo[i]) && (el[i] % per(mo[i])) < (mo[i] ? H1 : H0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      el[i] = 0; mb[i] = 0; mo[i] = 0; p0[i] = 0; p1[i] = 0; md[i] = 0;
    end
  endtask

  // Elapsed-time view: a burst plays for blen clocks, then idles gap clocks before the next grant.
  task automatic step(input bit r0, input bit r1);
    for (int i = 0; i < 2; i++) begin
      bit pre, ended, can, g, gid, s0, s1;
      int en;
      en = el[i] + 1;
      s0 = p0[i] | r0;
      s1 = p1[i] | r1;
`ifdef TONE_BURST_PREEMPT_EN
      pre = mb[i] && mo[i] && el[i] < blen(1'b1) && s0;
`else
      pre = 1'b0;
`endif
      ended = mb[i] && en == blen(mo[i]) + gap[i];
      md[i] = mb[i] && en == blen(mo[i]) && !pre;
      can = !mb[i] || ended;
      g = pre || (can && (s0 || s1));
      gid = !pre && !s0;
      p0[i] = s0 && !(g && !gid);
      p1[i] = s1 && !(g && gid);
      if (g) begin
        mb[i] = 1; mo[i] = gid; el[i] = 0;
      end else if (ended) begin
        mb[i] = 0; el[i] = 0;
      end else if (mb[i]) el[i] = en;
    end
  endtask

  task automatic compare();
    chk("a_out", a.out_o, exp_out(0));
    chk("a_busy", a.busy_o, mb[0]);
    chk("a_id", a.active_id_o, mo[0]);
    chk("a_done", a.done_o, md[0]);
    chk("b_out", b.out_o, exp_out(1));
    chk("b_busy", b.busy_o, mb[1]);
    chk("b_id", b.active_id_o, mo[1]);
    chk("b_done", b.done_o, md[1]);
  endtask

  task automatic cyc(input bit r0, input bit r1);
    a.req0_i = r0; a.req1_i = r1; b.req0_i = r0; b.req1_i = r1;
    @(posedge clk);
    step(r0, r1);
    @(negedge clk);
    compare();
  endtask

  initial begin
    int done_at;
    a.req0_i = 0; a.req1_i = 0; b.req0_i = 0; b.req1_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;
    done_at = -1;
    cyc(1, 0);
    for (int k = 1; k <= 40; k++) begin
      cyc(0, 0);
      if (a.done_o && done_at < 0) done_at = k;
    end
    chk("t1_done_edge", 8'(done_at), 8'd24);
    cyc(1, 1);
    repeat (55) cyc(0, 0);
    for (int k = 0; k <= 70; k++) cyc(k == 0 || k == 5 || k == 9 || k == 12, 0);
    for (int k = 0; k <= 50; k++) cyc(k == 3, k == 0);
    cyc(1, 0);
    for (int k = 1; k <= 10; k++) cyc(0, k == 6);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out", a.out_o, 1'b0);
    chk("rst_busy", a.busy_o, 1'b0);
    chk("rst_done", a.done_o, 1'b0);
    chk("rst_b_busy", b.busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cyc(0, 0);
    chk("post_rst_idle", a.busy_o, 1'b0);
    repeat (60) cyc(0, 1);
    repeat (30) cyc(0, 0);
    for (int k = 0; k < 3000; k++) begin
      bit hold;
      hold = (k / 400) % 3 == 2;
      cyc($urandom_range(0, 11) == 0, hold || $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("rnd_rst_out", a.out_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
